wb_seg_compare_regs: RTL and testbench
======================================

Name: wb_seg_compare_regs

Overview:
- Wishbone slave register block sitting directly upstream of the seven_segment_seconds counter.
- Lets firmware program the 24-bit compare value over the bus instead of the logic analyser.
- Produces the compare value, a one-cycle update strobe and the counter reset.
- Keeps a readable count of the updates it has issued.
- Lives inside the project wrapper, on the wrapper's buffered Wishbone outputs.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 16-byte register window; bits [3:0] ignored.
- DEFAULT_COMPARE, 24'd10_000_000, reset value of COMPARE.
- BLOCK_ID, 32'h5345_4731, constant returned by the ID register.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge, registered.
- wbs_dat_o  out  32  read data, registered.
- compare_out  out  24  compare value to the counter.
- update_compare  out  1  one-cycle load strobe to the counter.
- seg_reset  out  1  counter reset, level.

Behaviour:
- Register map, with offset = wbs_adr_i[3:2]:
  - 0x00 CTRL: bit0 SEG_RESET (RW, reset 1); bit1 AUTO_UPDATE (RW, reset 1); bit2 UPDATE (write-1 pulse, reads 0); other bits read 0.
  - 0x04 COMPARE: [23:0] RW, reset DEFAULT_COMPARE; [31:24] read 0, writes ignored.
  - 0x08 STATUS: read-only. [15:0] UPDATE_COUNT, [16] SEG_RESET mirror, rest 0. Writes ignored.
  - 0x0C ID: read-only, BLOCK_ID.
- Decode: hit = cyc & stb & !ack & (adr[31:4] == BASE_ADDR[31:4]). Non-hits are ignored and never acked.
- Handshake:
  - Hit sampled at the edge ending cycle N gives wbs_ack_o = 1 for cycle N+1 only.
  - Ack always drops in N+2, so a held request is acked every other cycle.
  - Ack pulses even if the master drops stb in N+1.
- Writes: take effect at the same edge that raises ack, so the new value is visible in cycle N+1.
  - Byte lanes are honoured: wbs_sel_i[k] gates bits [8k+7:8k].
  - CTRL bits 0–2 live in lane 0.
- Reads: wbs_dat_o is loaded at that edge with the addressed register. It is 0 in every cycle where ack is low.
- compare_out always equals COMPARE[23:0]. seg_reset always equals CTRL.SEG_RESET.
- update_compare, registered and high exactly in cycle N+1 when either:
  - a COMPARE write with any of sel[2:0] set lands while AUTO_UPDATE = 1 (AUTO_UPDATE value before the write), or
  - a CTRL write with sel[0] = 1 and dat[2] = 1.
  - A single access yields at most one pulse.
  - compare_out already holds the new value during the pulse.
- UPDATE_COUNT:
  - Increments by 1 on each update_compare pulse; wraps 0xFFFF to 0x0000.
  - A STATUS read in the pulse cycle returns the pre-increment value.
- Reset, asserted at any time including mid-access:
  - ack = 0, dat_o = 0, update_compare = 0 immediately.
  - CTRL = 3'b011, COMPARE = DEFAULT_COMPARE, UPDATE_COUNT = 0, seg_reset = 1.
  - A pending access is dropped; the master must retry.
- No combinational path from Wishbone inputs to any output.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C → 0x3, 0x0098_9680, 0x0001_0000, 0x5345_4731. seg_reset = 1. Each ack exactly one cycle.
- Write 0x04 = 0x00AB_CDEF, sel = 4'hF → compare_out = 0xABCDEF and update_compare = 1 in the ack cycle. Then a STATUS read returns 0x0001_0001.
- Write CTRL = 0x0 (clears AUTO_UPDATE and SEG_RESET), then COMPARE = 0x12 → no pulse. Then write CTRL = 0x4 → one pulse, compare_out = 0x12, seg_reset = 0, CTRL reads 0x0.
- Byte lanes: COMPARE = 0x00FFFFFF, then write 0x0000_0055 with sel = 4'h1 → COMPARE reads 0x00FF_FF55.
- Address 0x3000_0010 and stb held 4 cycles → no ack. Stb held at 0x3000_0008 → ack pattern 0,1,0,1.
- 65 536 forced updates → UPDATE_COUNT wraps to 0. Assert wb_rst_i mid-write while stb = 1 → ack low the same cycle, all registers at their reset values.

Source files
------------

// File: rtl/wb_seg_compare_regs.sv
// Wishbone register block that programs the seven-segment seconds counter:
// compare value, load strobe, counter reset and a count of issued loads.
module wb_seg_compare_regs #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [23:0] DEFAULT_COMPARE = 24'd10_000_000,
  parameter logic [31:0] BLOCK_ID        = 32'h5345_4731
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [23:0] compare_out,
  output logic        update_compare,
  output logic        seg_reset
);

  // Handshake: a request (cyc & stb in our 16-byte window) is taken at the
  // edge where ack is low; ack is then high for exactly one cycle, so a held
  // request is served every other cycle. Writes and read data land on the
  // same edge that raises ack; nothing combinational reaches the outputs.

  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic [1:0]  reg_off;
  logic        ctrl_write;
  logic        cmp_write;
  logic        update_next;
  logic [31:0] rd_data;
  logic [23:0] compare_next;

  logic        ctrl_seg_reset;
  logic        ctrl_auto_update;
  logic [23:0] compare_q;
  logic [15:0] update_count;

  // Address bits below the word, and data/lane bits with no backing storage.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

  assign reg_off = wbs_adr_i[3:2];
  assign hit     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                   (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_hit  = hit & wbs_we_i;
  assign rd_hit  = hit & ~wbs_we_i;

  assign ctrl_write = wr_hit && (reg_off == 2'd0);
  assign cmp_write  = wr_hit && (reg_off == 2'd1);

  // AUTO_UPDATE is sampled before this write, so a single access pulses once.
  assign update_next = (cmp_write & (|wbs_sel_i[2:0]) & ctrl_auto_update) |
                       (ctrl_write & wbs_sel_i[0] & wbs_dat_i[2]);

  always_comb begin
    rd_data = 32'd0;
    case (reg_off)
      2'd0:    rd_data = {30'd0, ctrl_auto_update, ctrl_seg_reset};
      2'd1:    rd_data = {8'd0, compare_q};
      2'd2:    rd_data = {15'd0, ctrl_seg_reset, update_count};
      default: rd_data = BLOCK_ID;
    endcase
  end

  always_comb begin
    compare_next = compare_q;
    for (int k = 0; k < 3; k++) begin
      if (wbs_sel_i[k]) compare_next[8*k +: 8] = wbs_dat_i[8*k +: 8];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o        <= 1'b0;
      wbs_dat_o        <= 32'd0;
      update_compare   <= 1'b0;
      ctrl_seg_reset   <= 1'b1;
      ctrl_auto_update <= 1'b1;
      compare_q        <= DEFAULT_COMPARE;
      update_count     <= 16'd0;
    end else begin
      wbs_ack_o      <= hit;
      wbs_dat_o      <= rd_hit ? rd_data : 32'd0;
      update_compare <= update_next;
      // Counting the registered pulse keeps a same-access STATUS read pre-increment.
      update_count   <= update_count + 16'(update_compare);
      if (ctrl_write && wbs_sel_i[0]) begin
        ctrl_seg_reset   <= wbs_dat_i[0];
        ctrl_auto_update <= wbs_dat_i[1];
      end
      if (cmp_write) compare_q <= compare_next;
    end
  end

  assign compare_out = compare_q;
  assign seg_reset   = ctrl_seg_reset;

endmodule

// File: tb/tb_wb_seg_compare_regs.sv
// Bench for wb_seg_compare_regs: directed vector table, held-strobe and reset
// sequences, randomized accesses scored against a register-map model.
module tb_wb_seg_compare_regs;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [23:0] DEF_CMP = 24'd10_000_000;
  localparam logic [31:0] ID_VAL  = 32'h5345_4731;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat = 32'd0;
  logic [31:0] adr = 32'd0;
  logic        ack;
  logic [31:0] dat_o;
  logic [23:0] compare_out;
  logic        update_compare;
  logic        seg_reset;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  wb_seg_compare_regs dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_dat_i     (dat),
    .wbs_adr_i     (adr),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_o),
    .compare_out   (compare_out),
    .update_compare(update_compare),
    .seg_reset     (seg_reset)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_seg;
  logic        m_auto;
  logic [23:0] m_cmp;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    m_seg  = 1'b1;
    m_auto = 1'b1;
    m_cmp  = DEF_CMP;
    m_cnt  = 16'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return {30'd0, m_auto, m_seg};
      2'd1:    return {8'd0, m_cmp};
      2'd2:    return {15'd0, m_seg, m_cnt};
      default: return ID_VAL;
    endcase
  endfunction

  function automatic logic model_write(input logic [1:0] off, input logic [3:0] s,
                                       input logic [31:0] d);
    logic        p;
    logic [23:0] mask;
    p = 1'b0;
    if (off == 2'd0 && s[0]) begin
      p      = d[2];
      m_seg  = d[0];
      m_auto = d[1];
    end else if (off == 2'd1) begin
      mask  = {{8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      p     = (mask != 24'd0) && m_auto;
      m_cmp = (m_cmp & ~mask) | (d[23:0] & mask);
    end
    if (p) m_cnt = m_cnt + 16'd1;
    return p;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic bus_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic got_ack,
                            output logic [31:0] rd, output logic p,
                            output logic [23:0] c, output logic sg);
    int waited;
    waited = 0;
    got_ack = 1'b0; rd = 32'd0; p = 1'b0; c = 24'd0; sg = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    while (!got_ack && waited < 8) begin
      @(posedge clk); #1;
      waited++;
      if (ack) begin
        got_ack = 1'b1;
        rd = dat_o; p = update_compare; c = compare_out; sg = seg_reset;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", 32'(got_ack), 32'd1);
    chk("ack_latency", 32'(waited), 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("pulse_one_cycle", 32'(update_compare), 32'd0);
    chk("dat_idle_zero", dat_o, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic        exp_pulse;
    logic [23:0] exp_cmp;
    logic        exp_seg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic w, input logic [31:0] a, input logic [3:0] s,
                                  input logic [31:0] d, input logic [31:0] er,
                                  input logic ep, input logic [23:0] ec, input logic es);
    vec_t v;
    v.we = w; v.adr = a; v.sel = s; v.dat = d;
    v.exp_rd = er; v.exp_pulse = ep; v.exp_cmp = ec; v.exp_seg = es;
    vecs.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    logic        ga;
    logic [31:0] rd;
    logic        p;
    logic        ep;
    logic [23:0] c;
    logic        sg;
    logic [31:0] exp_status;
    int          acks;
    int          cycles;

    //      we    adr           sel   dat            exp_rd         pulse cmp          seg
    add_vec(1'b0, BASE + 32'h0, 4'hF, 32'd0,         32'h0000_0003, 1'b0, 24'h989680, 1'b1);
    add_vec(1'b0, BASE + 32'h4, 4'hF, 32'd0,         32'h0098_9680, 1'b0, 24'h989680, 1'b1);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0001_0000, 1'b0, 24'h989680, 1'b1);
    add_vec(1'b0, BASE + 32'hC, 4'hF, 32'd0,         32'h5345_4731, 1'b0, 24'h989680, 1'b1);
    add_vec(1'b1, BASE + 32'h4, 4'hF, 32'h00AB_CDEF, 32'd0,         1'b1, 24'hABCDEF, 1'b1);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0001_0001, 1'b0, 24'hABCDEF, 1'b1);
    add_vec(1'b1, BASE + 32'h0, 4'hF, 32'h0,         32'd0,         1'b0, 24'hABCDEF, 1'b0);
    add_vec(1'b1, BASE + 32'h4, 4'hF, 32'h12,        32'd0,         1'b0, 24'h000012, 1'b0);
    add_vec(1'b1, BASE + 32'h0, 4'hF, 32'h4,         32'd0,         1'b1, 24'h000012, 1'b0);
    add_vec(1'b0, BASE + 32'h0, 4'hF, 32'd0,         32'h0000_0000, 1'b0, 24'h000012, 1'b0);
    add_vec(1'b1, BASE + 32'h4, 4'hF, 32'h00FF_FFFF, 32'd0,         1'b0, 24'hFFFFFF, 1'b0);
    add_vec(1'b1, BASE + 32'h4, 4'h1, 32'h0000_0055, 32'd0,         1'b0, 24'hFFFF55, 1'b0);
    add_vec(1'b0, BASE + 32'h4, 4'hF, 32'd0,         32'h00FF_FF55, 1'b0, 24'hFFFF55, 1'b0);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0000_0002, 1'b0, 24'hFFFF55, 1'b0);
    add_vec(1'b1, BASE + 32'h0, 4'h2, 32'h7,         32'd0,         1'b0, 24'hFFFF55, 1'b0);
    add_vec(1'b0, BASE + 32'h0, 4'hF, 32'd0,         32'h0000_0000, 1'b0, 24'hFFFF55, 1'b0);
    add_vec(1'b1, BASE + 32'h0, 4'h1, 32'h7,         32'd0,         1'b1, 24'hFFFF55, 1'b1);
    add_vec(1'b1, BASE + 32'h4, 4'h8, 32'hFF00_0000, 32'd0,         1'b0, 24'hFFFF55, 1'b1);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0001_0003, 1'b0, 24'hFFFF55, 1'b1);
    add_vec(1'b1, BASE + 32'h8, 4'hF, 32'hFFFF_FFFF, 32'd0,         1'b0, 24'hFFFF55, 1'b1);
    add_vec(1'b1, BASE + 32'h4, 4'h4, 32'h0011_0000, 32'd0,         1'b1, 24'h11FF55, 1'b1);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0001_0004, 1'b0, 24'h11FF55, 1'b1);
    add_vec(1'b1, BASE + 32'h0, 4'h1, 32'h6,         32'd0,         1'b1, 24'h11FF55, 1'b0);
    add_vec(1'b0, BASE + 32'h0, 4'hF, 32'd0,         32'h0000_0002, 1'b0, 24'h11FF55, 1'b0);
    add_vec(1'b1, BASE + 32'h4, 4'hF, 32'h0098_9680, 32'd0,         1'b1, 24'h989680, 1'b0);
    add_vec(1'b0, BASE + 32'h8, 4'hF, 32'd0,         32'h0000_0006, 1'b0, 24'h989680, 1'b0);

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_pulse", 32'(update_compare), 32'd0);
    chk("rst_compare_out", 32'(compare_out), 32'(DEF_CMP));
    chk("rst_seg_reset", 32'(seg_reset), 32'd1);

    foreach (vecs[i]) begin
      bus_access(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, ga, rd, p, c, sg);
      if (vecs[i].we) void'(model_write(vecs[i].adr[3:2], vecs[i].sel, vecs[i].dat));
      else chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pulse", i), 32'(p), 32'(vecs[i].exp_pulse));
      chk($sformatf("vec%0d_cmp", i), 32'(c), 32'(vecs[i].exp_cmp));
      chk($sformatf("vec%0d_seg", i), 32'(sg), 32'(vecs[i].exp_seg));
    end

    // Out-of-window address held: never acked.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("miss_no_ack", 32'(ack), 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Held STATUS read: ack alternates 0,1,0,1 starting in the request cycle.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h8;
    exp_status = model_read(2'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("held_ack_pattern", 32'(ack), 32'(k % 2));
      chk("held_dat", dat_o, (k % 2 == 1) ? exp_status : 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Randomized accesses scored against the model.
    for (int n = 0; n < 400; n++) begin
      logic        w;
      logic [1:0]  off;
      logic [3:0]  s;
      logic [31:0] d;
      w   = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      s   = 4'($urandom_range(0, 15));
      d   = $urandom;
      ep  = 1'b0;
      if (w) ep = model_write(off, s, d);
      else exp_q.push_back(model_read(off));
      bus_access(w, BASE | {28'd0, off, 2'($urandom_range(0, 3))}, s, d, ga, rd, p, c, sg);
      if (!w && exp_q.size() > 0) chk("rand_rd", rd, exp_q.pop_front());
      chk("rand_pulse", 32'(p), 32'(ep));
      chk("rand_cmp", 32'(c), 32'(m_cmp));
      chk("rand_seg", 32'(sg), 32'(m_seg));
    end

    // Counter wrap: clean reset, 65535 held UPDATE writes, then one more.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1; dat = 32'h4; adr = BASE;
    acks = 0;
    cycles = 0;
    while (acks < 65535 && cycles < 140000) begin
      @(posedge clk); #1;
      cycles++;
      if (ack) begin
        acks++;
        void'(model_write(2'd0, 4'h1, 32'h4));
        if (acks == 65535) begin
          cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("burst_acks", 32'(acks), 32'd65535);
    @(posedge clk); #1;
    bus_access(1'b0, BASE + 32'h8, 4'hF, 32'd0, ga, rd, p, c, sg);
    chk("count_ffff", rd, model_read(2'd2));
    chk("count_ffff_const", rd, 32'h0000_FFFF);
    ep = model_write(2'd0, 4'h1, 32'h4);
    bus_access(1'b1, BASE, 4'h1, 32'h4, ga, rd, p, c, sg);
    chk("wrap_pulse", 32'(p), 32'(ep));
    bus_access(1'b0, BASE + 32'h8, 4'hF, 32'd0, ga, rd, p, c, sg);
    chk("count_wrapped", rd, 32'h0000_0000);

    // Reset during an acked COMPARE write with the strobe still high.
    bus_access(1'b1, BASE, 4'h1, 32'h3, ga, rd, p, c, sg);
    void'(model_write(2'd0, 4'h1, 32'h3));
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat = 32'h0012_3456; adr = BASE + 32'h4;
    @(posedge clk); #1;
    chk("pre_rst_ack", 32'(ack), 32'd1);
    chk("pre_rst_pulse", 32'(update_compare), 32'd1);
    chk("pre_rst_cmp", 32'(compare_out), 32'h0012_3456);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_pulse", 32'(update_compare), 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    chk("mid_rst_cmp", 32'(compare_out), 32'(DEF_CMP));
    chk("mid_rst_seg", 32'(seg_reset), 32'd1);
    @(posedge clk); #1;
    chk("held_rst_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      bus_access(1'b0, BASE + 32'(4 * k), 4'hF, 32'd0, ga, rd, p, c, sg);
      chk($sformatf("post_rst_reg%0d", k), rd, model_read(2'(k)));
    end
    chk("post_rst_seg", 32'(seg_reset), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
